// File: rtl/neuron_pkg.sv
// neuron_pkg: shared widths, FSM state type and saturating arithmetic helpers for the neuron datapath
package neuron_pkg;

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int N_TERMS_D = 16;
    localparam int DIN_W_D   = 20;
    localparam int BIAS_W_D  = 8;
    localparam int ACC_W_D   = 24;
    localparam int OUT_W_D   = 8;

    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    typedef struct packed {
        wide_t val;
        logic  clamp;
    } sat_t;

    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic wide_t sext(input logic [MAX_W-1:0] v, input int w);
        wide_t t;
        t = wide_t'(v << (MAX_W - w));
        return t >>> (MAX_W - w);
    endfunction

    function automatic sat_t sat(input wide_t v, input int w);
        wide_t mx;
        wide_t mn;
        sat_t  r;
        mx      = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        mn      = -mx - wide_t'(1);
        r.clamp = (v > mx) || (v < mn);
        r.val   = v > mx ? mx : (v < mn ? mn : v);
        return r;
    endfunction

    function automatic sat_t sat_add(input wide_t a, input wide_t b, input int w);
        return sat(a + b, w);
    endfunction

endpackage

// File: rtl/neuron_acc_term_counter.sv
// term_counter: modulo-N beat index with first/last flags
module term_counter
    import neuron_pkg::*;
#(
    parameter  int N = N_TERMS_D,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] idx,
    output logic         is_first,
    output logic         is_last
);

    assign is_first = idx == '0;
    assign is_last  = idx == W'(N - 1);

    // advance per accepted beat, wrap only from the last index
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (inc)
            idx <= is_last ? '0 : idx + W'(1);
    end

endmodule

// File: rtl/neuron_acc.sv
// neuron_acc: handshaked saturating accumulator of N_TERMS partial products plus bias, with ReLU/requant output
module neuron_acc
    import neuron_pkg::*;
#(
    parameter  int N_TERMS = N_TERMS_D,
    parameter  int DIN_W   = DIN_W_D,
    parameter  int BIAS_W  = BIAS_W_D,
    parameter  int ACC_W   = ACC_W_D,
    parameter  int OUT_W   = OUT_W_D,
    parameter  int SHIFT   = 0,
    localparam int IDX_W   = idx_w(N_TERMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  din,
    input  logic [BIAS_W-1:0] bias,
    input  logic              relu_en,
    output logic [IDX_W-1:0]  term_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic [OUT_W-1:0]  act,
    output logic              ovf
);

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf_int;
    logic               w_beat;
    logic               w_first;
    logic               w_last;
    sat_t               w_add;
    sat_t               w_act_sat;
    wide_t              w_shift;
    logic               w_ovf;
    logic [OUT_W-1:0]   w_act;

    assign in_ready  = r_state == ACCUM;
    assign out_valid = r_state == HOLD;
    assign w_beat    = in_valid && in_ready && !clr;

    term_counter #(.N(N_TERMS)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (w_beat),
        .idx      (term_idx),
        .is_first (w_first),
        .is_last  (w_last)
    );

    // term 0 starts from the bias instead of the running sum; shift then clamp/ReLU for the activation
    always_comb begin
        w_add     = sat_add(w_first ? sext(MAX_W'(bias), BIAS_W) : sext(MAX_W'(r_acc), ACC_W),
                            sext(MAX_W'(din), DIN_W), ACC_W);
        w_ovf     = (!w_first && r_ovf_int) || w_add.clamp;
        w_shift   = w_add.val >>> SHIFT;
        w_act_sat = sat(w_shift, OUT_W);
        w_act     = (relu_en && w_shift < 0) ? '0 : w_act_sat.val[OUT_W-1:0];
    end

    // next state: clr aborts, last beat enters HOLD, out handshake returns to ACCUM
    always_comb begin
        w_next = r_state;
        if (clr)
            w_next = ACCUM;
        else if (w_beat && w_last)
            w_next = HOLD;
        else if (r_state == HOLD && out_ready)
            w_next = ACCUM;
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ACCUM;
        else
            r_state <= w_next;
    end

    // accumulator and result registers; results change only on a last beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf_int <= 1'b0;
            sum       <= '0;
            act       <= '0;
            ovf       <= 1'b0;
        end else if (clr) begin
            r_acc     <= '0;
            r_ovf_int <= 1'b0;
        end else if (w_beat && w_last) begin
            sum       <= w_add.val[ACC_W-1:0];
            act       <= w_act;
            ovf       <= w_ovf;
            r_acc     <= '0;
            r_ovf_int <= 1'b0;
        end else if (w_beat) begin
            r_acc     <= w_add.val[ACC_W-1:0];
            r_ovf_int <= w_ovf;
        end
    end

endmodule

// File: doc/neuron_acc.md
# neuron_acc

Parametrised, handshaked neuron accumulator that sits after the MAC array in the dense-layer datapath. It sums N_TERMS signed MAC partial products plus a signed bias, one term per accepted beat. It then presents the saturated sum and an optional ReLU/requantised activation on a valid/ready output port. It replaces the fixed-16-term, state-strobed accumulator with a beat counter, backpressure, saturation and an overflow flag.

## Interface
- N_TERMS, 16: terms per vector, ≥1
- DIN_W, 20: signed MAC input width
- BIAS_W, 8: signed bias width
- ACC_W, 24: signed accumulator/sum width, > DIN_W and > BIAS_W
- OUT_W, 8: signed activation width
- SHIFT, 0: arithmetic right shift applied before activation saturation
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous abort: discard partial vector and any held result
- in_valid  in  1  din beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- din  in  DIN_W  signed partial product
- bias  in  BIAS_W  signed bias, sampled on term 0 only
- relu_en  in  1  activation mode, sampled on last term
- term_idx  out  $clog2(N_TERMS) (min 1)  index of next expected term
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- sum  out  ACC_W  saturated signed sum
- act  out  OUT_W  activation
- ovf  out  1  saturation occurred in this vector

## Operation
- Two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1). Reset state is ACCUM.
- Term 0 beat: acc <= sat(sext(din) + sext(bias)).
- Other beats: acc <= sat(acc + sext(din)).
- When N_TERMS=1, the single beat adds both din and bias.
- sat(): compute at ACC_W+1 bits and clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. A clamp sets a sticky per-vector ovf_int.
- Last beat (term_idx==N_TERMS-1):
  - sum, ovf and act register from the final saturated value.
  - acc clears, term_idx returns to 0, state goes to HOLD.
- act computation:
  - s = sum >>> SHIFT.
  - If relu_en && s<0, act=0.
  - Otherwise clamp s to the OUT_W signed range.
- HOLD: sum, act and ovf are stable. in_valid is ignored. out_ready moves the state to ACCUM.
- clr has highest synchronous priority:
  - acc=0, term_idx=0, ovf_int=0, state=ACCUM, out_valid=0.
  - Any beat or out handshake in the same cycle is discarded.
- sum, act and ovf keep their last values until the next last beat; they are meaningful only while out_valid=1.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, act=0, ovf=0, term_idx=0, acc=0, state=ACCUM.
- Reset mid-vector aborts the vector immediately (asynchronously).
- One term accepted per cycle. out_valid rises the cycle after the last accepted beat.
- Out handshake in cycle t: in_ready=1 in t+1.
- Throughput: N_TERMS+1 cycles per vector with out_ready held high.
- in_ready depends only on state (registered), with no combinational path from out_ready.
- term_idx wraps N_TERMS-1 → 0 only on the last beat. A non-power-of-two N_TERMS never reaches an illegal index.

## Structure
- neuron_pkg holds:
  - state enum {ACCUM, HOLD};
  - sext and sat_add functions, parameterised through localparams;
  - the default width constants shared with the MAC array.
- One sub-module, term_counter: a parameterised N_TERMS counter with inc/clr inputs and is_first/is_last outputs.
- All other logic is in neuron_acc.

## Test plan
- Bias 8'hFF (-1), din=1 for 16 beats, relu_en=0 → out_valid one cycle after beat 16; sum=15, act=15, ovf=0.
- Bias 0, din=20'hFFFFE (-2) ×16:
  - relu_en=1 → sum=24'hFFFFE0, act=0.
  - Repeat with relu_en=0 → act=8'hE0.
- Bias 8'h7F, din=20'h7FFFF ×16 → sum=24'h7FFFFF, ovf=1, act=8'h7F. The next vector (din=1, bias 0) gives sum=16, ovf=0.
- out_ready low 5 cycles after result:
  - out_valid, sum and act hold; in_ready=0; in_valid pulses are ignored.
  - out_ready=1 → next vector is accepted the following cycle.
- clr after 9 beats → term_idx=0. The next 16 beats of din=2, bias 3 give sum=35.
- rst asserted asynchronously after 7 beats → all outputs reset without a clock edge. A fresh vector (din=1, bias 0) gives sum=16.
